// File: rtl/loss_pkg.sv
// loss_pkg: shared definitions for the batch mean-squared-error block.
//   loss_state_e : batch FSM states (ACCUM -> DRAIN -> HOLD -> ACCUM)
//   sq_width     : width of an unsigned square of a (pred_w+1)-bit signed difference
//   mean_width   : width of the mean after dividing the accumulator by 2^log2_batch
//   max_int      : helper for derived widths
package loss_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } loss_state_e;

  function automatic int sq_width(input int pred_w);
    return 2 * (pred_w + 1);
  endfunction

  function automatic int mean_width(input int acc_w, input int log2_batch);
    return acc_w - log2_batch;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sq_err_unit.sv
// sq_err_unit: two-stage squared-error pipeline.
//   S1 registers diff = predicted - target (signed, PRED_W+1 bits).
//   S2 registers sq = diff*diff (unsigned, SQ_W bits).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   flush_i           synchronous drop of both stage valids
//   accept_i          a sample is taken this cycle (loads S1)
//   target_i          target value (unsigned, TGT_W)
//   predicted_i       predicted value (unsigned, PRED_W)
//   busy_o            either stage holds a valid sample
//   sq_valid_o, sq_o  S2 output
module sq_err_unit
  import loss_pkg::*;
#(
  parameter int PRED_W = 21,
  parameter int TGT_W  = 4,
  localparam int SQ_W  = sq_width(PRED_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              accept_i,
  input  logic [TGT_W-1:0]  target_i,
  input  logic [PRED_W-1:0] predicted_i,
  output logic              busy_o,
  output logic              sq_valid_o,
  output logic [SQ_W-1:0]   sq_o
);

  logic signed [PRED_W:0] diff_d;
  logic signed [PRED_W:0] s1_diff_q;
  logic                   s1_valid_q;
  logic signed [SQ_W-1:0] diff_ext;
  logic signed [SQ_W-1:0] sq_d;
  logic [SQ_W-1:0]        s2_sq_q;
  logic                   s2_valid_q;

  // Both operands are zero-extended to PRED_W+1 so the result is a true signed difference.
  assign diff_d = $signed({1'b0, predicted_i}) - $signed({{(PRED_W + 1 - TGT_W){1'b0}}, target_i});

  // Sign-extend to full product width so the multiply is width-matched and exact.
  assign diff_ext = {{(PRED_W + 1){s1_diff_q[PRED_W]}}, s1_diff_q};
  assign sq_d     = diff_ext * diff_ext;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sq_q    <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept_i;
      if (accept_i) s1_diff_q <= diff_d;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_sq_q <= SQ_W'(sq_d);
    end
  end

  assign busy_o     = s1_valid_q | s2_valid_q;
  assign sq_valid_o = s2_valid_q;
  assign sq_o       = s2_sq_q;

endmodule

// File: rtl/mse_batch_loss.sv
// mse_batch_loss: mean squared error over batches of 2^LOG2_BATCH samples.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   clear_i                       synchronous batch flush, overrides everything
//   in_valid_i, in_ready_o        sample handshake; target_i / predicted_i carry the sample
//   loss_valid_o, loss_ready_i    mean handshake; loss_o is the batch mean
//   ovf_o                         accumulator overflowed in this batch (saturating build only)
//   state_o                       current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid holds its payload until that edge. clear_i cancels any transfer in its cycle.
// Build option: define LOSS_SATURATE_EN to clamp the accumulator and report ovf_o;
// otherwise the accumulator wraps and ovf_o is tied low.
module mse_batch_loss
  import loss_pkg::*;
#(
  parameter int PRED_W     = 21,
  parameter int TGT_W      = 4,
  parameter int LOG2_BATCH = 3,
  parameter int ACC_W      = 48
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        clear_i,
  input  logic                                        in_valid_i,
  output logic                                        in_ready_o,
  input  logic [TGT_W-1:0]                            target_i,
  input  logic [PRED_W-1:0]                           predicted_i,
  output logic                                        loss_valid_o,
  input  logic                                        loss_ready_i,
  output logic [mean_width(ACC_W, LOG2_BATCH)-1:0]    loss_o,
  output logic                                        ovf_o,
  output loss_state_e                                 state_o
);

  localparam int SQ_W   = sq_width(PRED_W);
  localparam int SUM_W  = max_int(ACC_W, SQ_W) + 1;
  localparam int MEAN_W = mean_width(ACC_W, LOG2_BATCH);
  localparam int CNT_W  = LOG2_BATCH + 1;
  localparam int BATCH  = 1 << LOG2_BATCH;

  loss_state_e         state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [ACC_W-1:0]    acc_q, acc_add;
  logic [SUM_W-1:0]    sum_d;
  logic [MEAN_W-1:0]   loss_q;
  logic                accept, busy, sq_valid, batch_done, drain_done;
  logic [SQ_W-1:0]     sq;

  assign accept     = in_valid_i && in_ready_o && !clear_i;
  assign batch_done = (state_q == ST_HOLD) && loss_ready_i && !clear_i;
  assign drain_done = (state_q == ST_DRAIN) && !busy;

  sq_err_unit #(
    .PRED_W (PRED_W),
    .TGT_W  (TGT_W)
  ) u_sq_err_unit (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clear_i),
    .accept_i    (accept),
    .target_i    (target_i),
    .predicted_i (predicted_i),
    .busy_o      (busy),
    .sq_valid_o  (sq_valid),
    .sq_o        (sq)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (accept && (count_q == CNT_W'(BATCH - 1))) state_d = ST_DRAIN;
        ST_DRAIN: if (!busy) state_d = ST_HOLD;
        ST_HOLD:  if (loss_ready_i) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // FSM outputs: in_ready is a pure state decode; loss_valid is withdrawn under clear
  // so no mean can be consumed in a flush cycle.
  always_comb begin
    in_ready_o   = (state_q == ST_ACCUM);
    loss_valid_o = (state_q == ST_HOLD) && !clear_i;
  end

  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   count_q <= '0;
    else if (clear_i || batch_done) count_q <= '0;
    else if (accept)              count_q <= count_q + 1'b1;
  end

  // One bit wider than either operand so a carry out of ACC_W is always visible.
  assign sum_d = SUM_W'(acc_q) + SUM_W'(sq);

`ifdef LOSS_SATURATE_EN
  logic sat;
  logic ovf_q;

  assign sat     = (sum_d >> ACC_W) != '0;
  assign acc_add = sat ? '1 : ACC_W'(sum_d);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     ovf_q <= 1'b0;
    else if (clear_i || batch_done) ovf_q <= 1'b0;
    else if (sq_valid && sat)       ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`else
  assign acc_add = ACC_W'(sum_d);
  assign ovf_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     acc_q <= '0;
    else if (clear_i || batch_done) acc_q <= '0;
    else if (sq_valid)              acc_q <= acc_add;
  end

  // Pipeline is empty in the drain-exit cycle, so acc_q already includes the last sample.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                       loss_q <= '0;
    else if (drain_done && !clear_i)  loss_q <= MEAN_W'(acc_q >> LOG2_BATCH);
  end

  assign loss_o = loss_q;

endmodule

// File: tb/tb_mse_batch_loss.sv
// tb_mse_batch_loss: directed bench for mse_batch_loss. A default-parameter instance
// and an ACC_W=8 instance share all inputs; expected values are hand-computed.
module tb_mse_batch_loss;
  import loss_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        loss_ready;
  logic [3:0]  target;
  logic [20:0] predicted;

  logic        in_ready, loss_valid, ovf;
  logic [44:0] loss;
  loss_state_e state;

  logic        in_ready8, loss_valid8, ovf8;
  logic [4:0]  loss8;
  loss_state_e state8;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mse_batch_loss u_dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .clear_i      (clear),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .target_i     (target),
    .predicted_i  (predicted),
    .loss_valid_o (loss_valid),
    .loss_ready_i (loss_ready),
    .loss_o       (loss),
    .ovf_o        (ovf),
    .state_o      (state)
  );

  mse_batch_loss #(.ACC_W(8)) u_dut8 (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .clear_i      (clear),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready8),
    .target_i     (target),
    .predicted_i  (predicted),
    .loss_valid_o (loss_valid8),
    .loss_ready_i (loss_ready),
    .loss_o       (loss8),
    .ovf_o        (ovf8),
    .state_o      (state8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: holds one sample on the bus for n accepting edges; starts and ends 1ns after an edge
  task automatic send(input int n, input logic [3:0] t, input logic [20:0] p);
    in_valid  = 1'b1;
    target    = t;
    predicted = p;
    repeat (n) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_loss(input string tag);
    int i;
    i = 0;
    while (!loss_valid && i < 20) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_wait"}, 64'(loss_valid), 64'd1);
  endtask

  task automatic take_loss(input string tag);
    loss_ready = 1'b1;
    @(posedge clk);
    #1;
    loss_ready = 1'b0;
    check({tag, "_lv_drop"}, 64'(loss_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  logic [63:0] exp_loss8, exp_ovf8;

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    loss_ready = 1'b0;
    target     = '0;
    predicted  = '0;
`ifdef LOSS_SATURATE_EN
    exp_loss8 = 64'd31;
    exp_ovf8  = 64'd1;
`else
    exp_loss8 = 64'd16;
    exp_ovf8  = 64'd0;
`endif

    // reset state
    #2;
    check("rst_loss", 64'(loss), 64'd0);
    check("rst_lv", 64'(loss_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_state", 64'(state), 64'(ST_ACCUM));
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 8 x (t=3,p=5): sq=4, mean 4; latency 3 cycles from the 8th accept
    send(8, 4'd3, 21'd5);
    check("lat_c0_lv", 64'(loss_valid), 64'd0);
    check("drain_state", 64'(state), 64'(ST_DRAIN));
    check("drain_in_ready", 64'(in_ready), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_c%0d_lv", k), 64'(loss_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    check("b1_loss", 64'(loss), 64'd4);
    check("b1_ovf", 64'(ovf), 64'd0);
    check("b1_state", 64'(state), 64'(ST_HOLD));
    take_loss("b1");
    check("b1_loss_kept", 64'(loss), 64'd4);

    // 8 x (t=15,p=0): diff -15, mean 225; held for 10 cycles
    send(8, 4'd15, 21'd0);
    wait_loss("b2");
    check("b2_loss", 64'(loss), 64'd225);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("b2_hold_loss", 64'(loss), 64'd225);
      check("b2_hold_in_ready", 64'(in_ready), 64'd0);
      check("b2_hold_lv", 64'(loss_valid), 64'd1);
    end
    take_loss("b2");

    // 4 x (t=1,p=9) then clear (with a sample offered), then 8 x (t=0,p=2) -> 4
    send(4, 4'd1, 21'd9);
    clear    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_state", 64'(state), 64'(ST_ACCUM));
    check("clr_lv", 64'(loss_valid), 64'd0);
    send(8, 4'd0, 21'd2);
    wait_loss("b3");
    check("b3_loss", 64'(loss), 64'd4);
    take_loss("b3");

    // 5 x (t=0,p=10), async reset mid-batch, then 8 x (t=2,p=6) -> 16
    send(5, 4'd0, 21'd10);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_loss", 64'(loss), 64'd0);
    check("mid_rst_lv", 64'(loss_valid), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_state", 64'(state), 64'(ST_ACCUM));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8, 4'd2, 21'd6);
    wait_loss("b4");
    check("b4_loss", 64'(loss), 64'd16);
    take_loss("b4");

    // maximum predicted, target 0: mean = (2^21-1)^2 = 2^42 - 2^22 + 1
    send(8, 4'd0, 21'h1FFFFF);
    wait_loss("b5");
    check("b5_loss", 64'(loss), 64'd4398042316801);
    check("b5_ovf", 64'(ovf), 64'd0);
    take_loss("b5");

    // 8 x (t=0,p=20): sq=400; ACC_W=8 instance wraps to 16 or clamps to 31
    send(8, 4'd0, 21'd20);
    wait_loss("b6");
    check("b6_loss", 64'(loss), 64'd400);
    check("b6_lv8", 64'(loss_valid8), 64'd1);
    check("b6_loss8", 64'(loss8), exp_loss8);
    check("b6_ovf8", 64'(ovf8), exp_ovf8);
    take_loss("b6");
    check("b6_ovf8_cleared", 64'(ovf8), 64'd0);
    check("b6_lv8_drop", 64'(loss_valid8), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mse_batch_loss.md
MSE_BATCH_LOSS -- requirements
Module: mse_batch_loss

Interface
REQ-001 SHALL have parameter PRED_W, default 21, predicted operand width (unsigned).
REQ-002 SHALL have parameter TGT_W, default 4, target operand width (unsigned, TGT_W <= PRED_W).
REQ-003 SHALL have parameter LOG2_BATCH, default 3, log2 of samples per batch (BATCH = 2^LOG2_BATCH).
REQ-004 SHALL have parameter ACC_W, default 48, accumulator width; SQ_W = 2*(PRED_W+1) is the derived square width.
REQ-005 SHALL have port clk_i, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port clear_i, input, 1, synchronous batch flush.
REQ-008 SHALL have port in_valid_i, input, 1, sample valid.
REQ-009 SHALL have port in_ready_o, output, 1, sample accepted when valid and ready are both 1.
REQ-010 SHALL have port target_i, input, TGT_W, target value.
REQ-011 SHALL have port predicted_i, input, PRED_W, predicted value.
REQ-012 SHALL have port loss_valid_o, output, 1, mean loss available.
REQ-013 SHALL have port loss_ready_i, input, 1, consumer accepts the loss.
REQ-014 SHALL have port loss_o, output, ACC_W-LOG2_BATCH, batch mean squared error.
REQ-015 SHALL have port ovf_o, output, 1, batch accumulator overflowed (sticky per batch).

Function
REQ-016 SHALL compute per sample diff = predicted_i - zero-extended target_i as a signed PRED_W+1 value, and sq = diff*diff as unsigned SQ_W.
REQ-017 SHALL implement a 2-stage pipeline: S1 registers diff, S2 registers sq; each stage carries its own valid bit.
REQ-018 SHALL add sq to the accumulator in the cycle after S2 is valid, computing the add at width max(ACC_W,SQ_W)+1.
REQ-019 SHALL implement FSM states ACCUM, DRAIN and HOLD; the reset state is ACCUM.
REQ-020 ACCUM: in_ready_o=1; each handshake increments sample count; the handshake that makes count reach BATCH moves the FSM to DRAIN.
REQ-021 DRAIN: in_ready_o=0; once S1, S2 and the final accumulate are done, register loss_o = acc >> LOG2_BATCH and move to HOLD.
REQ-022 Latency: loss_valid_o SHALL rise exactly 3 cycles after the clock edge that accepts the BATCH-th sample.
REQ-023 HOLD: loss_valid_o=1; loss_o and ovf_o are stable; in_ready_o=0; the FSM holds until loss_ready_i=1.
REQ-024 On the HOLD handshake cycle, SHALL go to ACCUM with acc, count and ovf cleared; loss_o keeps its value and loss_valid_o drops.
REQ-025 clear_i=1 SHALL take priority over everything: next state ACCUM; acc, count, pipeline valids and ovf cleared; loss_valid_o=0; no sample accepted in that cycle.
REQ-026 in_ready_o SHALL be a registered state decode and SHALL NOT depend combinationally on in_valid_i.

Reset
REQ-027 While rst_i=0, SHALL asynchronously set: state ACCUM, count 0, acc 0, pipeline valids 0, loss_o 0, loss_valid_o 0, ovf_o 0.
REQ-028 A reset asserted mid-batch SHALL discard all partial work; after release the first accepted sample starts a new batch.

Configuration
REQ-029 With LOSS_SATURATE_EN defined, an add result above 2^ACC_W-1 SHALL clamp acc to all-ones and set ovf, which stays set until the batch ends.
REQ-030 Without LOSS_SATURATE_EN, acc SHALL take the ACC_W LSBs (wrap) and ovf_o SHALL be tied to 0.

Structure
REQ-031 Package loss_pkg SHALL hold the FSM state enum and the SQ_W/mean-width derivation functions.
REQ-032 Sub-module sq_err_unit SHALL contain the two pipeline stages (diff and square with their valids); mse_batch_loss holds the FSM, counter and accumulator.

Verification
REQ-033 Defaults, 8 samples target=3 predicted=5 back-to-back -> loss_o=4, ovf_o=0, loss_valid_o 3 cycles after the 8th accept.
REQ-034 Defaults, 8 samples target=15 predicted=0 -> loss_o=225; hold loss_ready_i=0 for 10 cycles -> loss_o stable and in_ready_o=0 throughout.
REQ-035 4 samples accepted, then clear_i pulse, then 8 samples target=0 predicted=2 -> loss_o=4 (pre-clear samples excluded).
REQ-036 rst_i low for 1 cycle after 5 samples -> all outputs 0 immediately; the next 8 samples produce the correct mean alone.
REQ-037 ACC_W=8, 8 samples target=0 predicted=20 -> with LOSS_SATURATE_EN: loss_o=31, ovf_o=1; without it: loss_o=16, ovf_o=0.
